muxn_cfu: RTL and testbench

- Parametrised N-target CFU-L2 request/response multiplexer; successor to the fixed 3-way mux.
- Steers each request to the target CFU named by `req_cfu`.
- Returns responses strictly in request order, even when targets have different latencies, using an order FIFO of target indices.
- Sits between a CPU-side CFU-L2 initiator and N composed stateful CFUs (e.g. mulacc_l2_cfu instances with differing CFU_LATENCY).

---
 rtl/cfu_pkg.sv | 22 ++
 rtl/cfu_order_fifo.sv | 51 +++++
 rtl/muxn_cfu.sv | 148 ++++++++++++++
 tb/tb_muxn_cfu.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_pkg.sv
// Shared CFU-L2 types for the N-target request/response multiplexer.
package cfu_pkg;

  // Function id: funct7 concatenated with funct3.
  typedef logic [9:0] cfid_t;

  typedef enum logic [1:0] {
    CFU_OK    = 2'd0,
    CFU_ERROR = 2'd1
  } cfu_status_t;

  // Largest target count the order-FIFO index type is sized for.
  // One extra code is kept free for the error entry.
  localparam int unsigned MUXN_MAX_CFUS = 16;
  typedef logic [$clog2(MUXN_MAX_CFUS + 1)-1:0] muxn_idx_t;

  // Width of a field that may be configured to zero bits.
  function automatic int unsigned cfu_field_w(input int unsigned w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/cfu_order_fifo.sv
// Order FIFO of target indices: remembers which target owes the next response.
module cfu_order_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (PW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clk_en) begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW + 1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PW + 1)'(1);
    end
  end

  // Entry storage; contents are only meaningful while the entry is occupied.
  always_ff @(posedge i_clk) begin
    if (i_clk_en && w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/muxn_cfu.sv
// N-target CFU-L2 mux with in-order response return.
// Optional feature macro: MUXN_CFU_ERR_EN (out-of-range req_cfu answered with CFU_ERROR).
module muxn_cfu
  import cfu_pkg::*;
#(
  parameter int unsigned N_CFUS    = 4,
  parameter int unsigned N_STATES  = 1,
  parameter int unsigned FUNC_ID_W = $bits(cfid_t),
  parameter int unsigned INSN_W    = 0,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        clk_en,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [$clog2(N_CFUS):0]                     req_cfu,
  input  logic [(N_STATES > 1 ? $clog2(N_STATES) : 1)-1:0] req_state,
  input  logic [FUNC_ID_W-1:0]                        req_func,
  input  logic [(INSN_W > 0 ? INSN_W : 1)-1:0]        req_insn,
  input  logic [DATA_W-1:0]                           req_data0,
  input  logic [DATA_W-1:0]                           req_data1,
  output logic                                        resp_valid,
  input  logic                                        resp_ready,
  output cfu_status_t                                 resp_status,
  output logic [DATA_W-1:0]                           resp_data,
  output logic [N_CFUS-1:0]                           t_req_valid,
  input  logic [N_CFUS-1:0]                           t_req_ready,
  output logic [(N_STATES > 1 ? $clog2(N_STATES) : 1)-1:0] t_req_state [N_CFUS],
  output logic [FUNC_ID_W-1:0]                        t_req_func  [N_CFUS],
  output logic [(INSN_W > 0 ? INSN_W : 1)-1:0]        t_req_insn  [N_CFUS],
  output logic [DATA_W-1:0]                           t_req_data0 [N_CFUS],
  output logic [DATA_W-1:0]                           t_req_data1 [N_CFUS],
  input  logic [N_CFUS-1:0]                           t_resp_valid,
  output logic [N_CFUS-1:0]                           t_resp_ready,
  input  cfu_status_t                                 t_resp_status [N_CFUS],
  input  logic [DATA_W-1:0]                           t_resp_data   [N_CFUS]
);

  localparam int unsigned IW = $clog2(N_CFUS);
`ifdef MUXN_CFU_ERR_EN
  localparam int unsigned EW = IW + 1;
`else
  localparam int unsigned EW = IW;
`endif

  logic              r_live;
  logic              w_go;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_err;
  logic [IW-1:0]     w_sel;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_head;
  logic              w_tgt_rdy;
  logic              w_hd_valid;
  cfu_status_t       w_hd_status;
  logic [DATA_W-1:0] w_hd_data;

  assign w_sel = req_cfu[IW-1:0];

`ifdef MUXN_CFU_ERR_EN
  assign w_err   = (req_cfu >= (IW + 1)'(N_CFUS));
  assign w_entry = w_err ? EW'(N_CFUS) : {1'b0, w_sel};
`else
  // Top select bit is ignored: every request lands on some target.
  logic w_unused_cfu_msb;
  assign w_unused_cfu_msb = req_cfu[IW];
  assign w_err   = 1'b0;
  assign w_entry = w_sel;
`endif

  // Handshakes are blocked while stalled, in reset, and in the first cycle after reset.
  assign w_go = clk_en && r_live && !rst;

  // Tracks whether the cycle following reset has passed.
  always_ff @(posedge clk) begin
    if (rst)         r_live <= 1'b0;
    else if (clk_en) r_live <= 1'b1;
  end

  // Payload is broadcast; only the selected target sees a valid.
  always_comb begin
    for (int i = 0; i < N_CFUS; i++) begin
      t_req_state[i] = req_state;
      t_req_func[i]  = req_func;
      t_req_insn[i]  = req_insn;
      t_req_data0[i] = req_data0;
      t_req_data1[i] = req_data1;
    end
  end

  // Request steering and head-of-order response selection.
  always_comb begin
    w_tgt_rdy    = 1'b0;
    w_hd_valid   = 1'b0;
    w_hd_status  = CFU_OK;
    w_hd_data    = '0;
    t_req_valid  = '0;
    t_resp_ready = '0;
    for (int i = 0; i < N_CFUS; i++) begin
      if (!w_err && (w_sel == IW'(i))) begin
        w_tgt_rdy      = t_req_ready[i];
        t_req_valid[i] = req_valid && !w_full && w_go;
      end
      if (w_head == EW'(i)) begin
        w_hd_valid      = t_resp_valid[i];
        w_hd_status     = t_resp_status[i];
        w_hd_data       = t_resp_data[i];
        t_resp_ready[i] = resp_ready && !w_empty && w_go;
      end
    end
`ifdef MUXN_CFU_ERR_EN
    if (w_head == EW'(N_CFUS)) begin
      w_hd_valid  = 1'b1;
      w_hd_status = CFU_ERROR;
      w_hd_data   = '0;
    end
`endif
    // Full blocks requests even if a pop happens this cycle.
    req_ready   = w_go && !w_full && (w_err || w_tgt_rdy);
    resp_valid  = w_go && !w_empty && w_hd_valid;
    resp_status = resp_valid ? w_hd_status : CFU_OK;
    resp_data   = resp_valid ? w_hd_data : '0;
  end

  assign w_push = req_valid && req_ready;
  assign w_pop  = resp_valid && resp_ready;

  cfu_order_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clk_en (clk_en),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_data   (w_entry),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

endmodule

// File: tb/tb_muxn_cfu.sv
// Bench for muxn_cfu: behavioural targets with latencies 5/3/1/1 and a response scoreboard.
module tb_muxn_cfu;
  import cfu_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FW = $bits(cfid_t);

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] d;
  } exp_t;

  typedef struct packed {
    logic [31:0] d;
    int unsigned due;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clk_en, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]    req_cfu;
  logic [0:0]    req_state, req_insn;
  logic [FW-1:0] req_func;
  logic [DW-1:0] req_data0, req_data1, resp_data;
  cfu_status_t   resp_status;
  logic [N-1:0]  t_req_valid, t_req_ready, t_resp_valid, t_resp_ready;
  logic [0:0]    t_req_state [N];
  logic [FW-1:0] t_req_func  [N];
  logic [0:0]    t_req_insn  [N];
  logic [DW-1:0] t_req_data0 [N];
  logic [DW-1:0] t_req_data1 [N];
  cfu_status_t   t_resp_status [N];
  logic [DW-1:0] t_resp_data   [N];

  exp_t        exp_q[$];
  job_t        tq[N][$];
  exp_t        cur_exp;
  int          acc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;

  muxn_cfu dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cfu       (req_cfu),
    .req_state     (req_state),
    .req_func      (req_func),
    .req_insn      (req_insn),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_status   (resp_status),
    .resp_data     (resp_data),
    .t_req_valid   (t_req_valid),
    .t_req_ready   (t_req_ready),
    .t_req_state   (t_req_state),
    .t_req_func    (t_req_func),
    .t_req_insn    (t_req_insn),
    .t_req_data0   (t_req_data0),
    .t_req_data1   (t_req_data1),
    .t_resp_valid  (t_resp_valid),
    .t_resp_ready  (t_resp_ready),
    .t_resp_status (t_resp_status),
    .t_resp_data   (t_resp_data)
  );

  function automatic int unsigned lat(input int i);
    case (i)
      0:       return 5;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Behavioural targets: multiply operands, answer after lat(i) cycles, hold until taken.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (rst) tq[i].delete();
      else begin
        if (t_resp_valid[i] && t_resp_ready[i]) void'(tq[i].pop_front());
        if (t_req_valid[i] && t_req_ready[i])
          tq[i].push_back('{d: t_req_data0[i] * t_req_data1[i], due: cyc + lat(i)});
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      t_resp_status[i] = CFU_OK;
      if (tq[i].size() > 0 && tq[i][0].due <= cyc) begin
        t_resp_valid[i] = 1'b1;
        t_resp_data[i]  = tq[i][0].d;
      end else begin
        t_resp_valid[i] = 1'b0;
        t_resp_data[i]  = '0;
      end
    end
  end

  // Scoreboard: expectation queued on accept, compared when a response is taken.
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (req_valid && req_ready) begin
        exp_q.push_back(cur_exp);
        acc_cnt++;
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else chk("resp_order", {resp_status, resp_data}, exp_q.pop_front());
      end
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int cfu, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int a0;
    int t;
    a0 = acc_cnt;
    t = 0;
    req_valid = 1'b1;
    req_cfu   = 3'(cfu);
    req_data0 = a;
    req_data1 = b;
    cur_exp   = e;
    do begin
      nstep();
      t++;
    end while (acc_cnt == a0 && t < 20);
    if (acc_cnt == a0) chk("send_timeout", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      nstep();
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int t;
    int seen;
    rst = 1'b1; clk_en = 1'b1; req_valid = 1'b1; req_cfu = '0; req_state = '0;
    req_func = '0; req_insn = '0; req_data0 = '0; req_data1 = '0; resp_ready = 1'b1;
    t_req_ready = '1; cur_exp = '0;

    // Reset holds every handshake low even with a request offered.
    repeat (3) begin
      nstep();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_t_req_valid", 64'(t_req_valid), 64'd0);
      chk("rst_t_resp_ready", 64'(t_resp_ready), 64'd0);
      chk("rst_resp_data", {30'd0, resp_status, resp_data}, 64'd0);
    end
    rst = 1'b0;
    #1 chk("post_rst_req_ready", 64'(req_ready), 64'd0);
    chk("post_rst_t_req_valid", 64'(t_req_valid), 64'd0);
    req_valid = 1'b0;
    nstep();

    // Out-of-order completion returned in request order.
    send(0, 32'd2, 32'd3, '{CFU_OK, 32'd6});
    send(1, 32'd4, 32'd5, '{CFU_OK, 32'd20});
    send(2, 32'd6, 32'd7, '{CFU_OK, 32'd42});
    t = 0;
    while (!t_resp_valid[2] && t < 20) begin nstep(); t++; end
    chk("t2_done", 64'(t_resp_valid[2]), 64'd1);
    chk("t2_stalled", 64'(t_resp_ready[2]), 64'd0);
    chk("head_not_ready", 64'(resp_valid), 64'd0);
    t = 0;
    while (!resp_valid && t < 20) begin nstep(); t++; end
    chk("head_ready", 64'(resp_valid), 64'd1);
    chk("t1_held", 64'(t_resp_valid[1]), 64'd1);
    chk("t2_held", 64'(t_resp_valid[2]), 64'd1);
    drain();

    // Full FIFO: four accepted, then the fifth only after the first pop.
    resp_ready = 1'b0;
    a0 = acc_cnt;
    req_valid = 1'b1;
    req_cfu = 3'd3;
    repeat (6) begin
      req_data0 = 32'(acc_cnt - a0 + 1);
      req_data1 = 32'd10;
      cur_exp = '{CFU_OK, 32'((acc_cnt - a0 + 1) * 10)};
      nstep();
    end
    chk("full_accepts", 64'(acc_cnt - a0), 64'd4);
    chk("full_ready", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    #1 chk("pop_cycle_ready", 64'(req_ready), 64'd0);
    chk("pop_cycle_valid", 64'(resp_valid), 64'd1);
    nstep();
    chk("after_pop_ready", 64'(req_ready), 64'd1);
    nstep();
    chk("fifth_accept", 64'(acc_cnt - a0), 64'd5);
    req_valid = 1'b0;
    drain();

    // Streaming to a latency-1 target.
    a0 = acc_cnt;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_cfu   = 3'd3;
      req_data0 = 32'(i);
      req_data1 = 32'(i + 1);
      cur_exp   = '{CFU_OK, 32'(i * (i + 1))};
      #1 chk("stream_ready", 64'(req_ready), 64'd1);
      nstep();
    end
    req_valid = 1'b0;
    chk("stream_accepts", 64'(acc_cnt - a0), 64'd16);
    drain();

    // Reset with three requests outstanding.
    resp_ready = 1'b0;
    send(0, 32'd1, 32'd1, '{CFU_OK, 32'd1});
    send(1, 32'd2, 32'd2, '{CFU_OK, 32'd4});
    send(2, 32'd3, 32'd3, '{CFU_OK, 32'd9});
    rst = 1'b1;
    nstep();
    rst = 1'b0;
    resp_ready = 1'b1;
    #1 chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_t_resp_ready", 64'(t_resp_ready), 64'd0);
    seen = 0;
    repeat (10) begin
      nstep();
      if (resp_valid) seen++;
    end
    chk("midrst_no_resp", 64'(seen), 64'd0);
    send(2, 32'd8, 32'd9, '{CFU_OK, 32'd72});
    drain();

    // Out-of-range target select.
`ifdef MUXN_CFU_ERR_EN
    send(0, 32'd3, 32'd3, '{CFU_OK, 32'd9});
    req_valid = 1'b1;
    req_cfu   = 3'd4;
    cur_exp   = '{CFU_ERROR, 32'd0};
    #1 chk("err_no_target", 64'(t_req_valid), 64'd0);
    chk("err_ready", 64'(req_ready), 64'd1);
    nstep();
    req_valid = 1'b0;
    drain();
`else
    req_valid = 1'b1;
    req_cfu   = 3'd4;
    req_data0 = 32'd5;
    req_data1 = 32'd6;
    cur_exp   = '{CFU_OK, 32'd30};
    #1 chk("trunc_target", 64'(t_req_valid), 64'd1);
    nstep();
    req_valid = 1'b0;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
